// File: rtl/phasor_bank_if.sv
// Voice-parameter / output bus of the phasor bank.
// The master is the parameter register file and sample scheduler. The slave is the accumulator bank.
interface phasor_bank_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 12,
    parameter int unsigned NV = 8
);
    localparam int unsigned IW = DW - AW;
    localparam int unsigned VW = $clog2(NV);

    logic          En;
    logic          sample_tick;
    logic [NV-1:0] sync_mask;
    logic [VW-1:0] req_voice;
    logic [DW-1:0] phase_increment;
    logic [DW-1:0] fm_input;
    logic [DW-1:0] phase_offset;
    logic          out_valid;
    logic [VW-1:0] out_voice;
    logic [AW-1:0] wavetable_addr;
    logic [IW-1:0] interp;
    logic          wrapped;
    logic          frame_done;
    logic          overrun;

    modport master (
        output En, sample_tick, sync_mask, phase_increment, fm_input, phase_offset,
        input  req_voice, out_valid, out_voice, wavetable_addr, interp, wrapped,
               frame_done, overrun
    );

    modport slave (
        input  En, sample_tick, sync_mask, phase_increment, fm_input, phase_offset,
        output req_voice, out_valid, out_voice, wavetable_addr, interp, wrapped,
               frame_done, overrun
    );
endinterface

// File: rtl/phasor_bank.sv
// Time-multiplexed bank of NV phase accumulators.
// A sample_tick starts a frame, and one voice is serviced per enabled clock after that.
module phasor_bank #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 12,
    parameter int unsigned NV = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    phasor_bank_if.slave  bus
);
    localparam int unsigned IW = DW - AW;
    localparam int unsigned VW = $clog2(NV);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [VW-1:0] voice_cnt_q, voice_cnt_d;
    logic [NV-1:0] sync_q, sync_d;
    logic [DW-1:0] phase_q [NV];
    logic [DW-1:0] phase_d [NV];

    logic          out_valid_q, out_valid_d;
    logic [VW-1:0] out_voice_q, out_voice_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] interp_q, interp_d;
    logic          wrapped_q, wrapped_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q, overrun_d;

    logic [DW-1:0] freq;
    logic [DW-1:0] lookup;
    logic [DW:0]   sum;

    // Datapath for the voice currently presented on the bus.
    always_comb begin
        freq   = bus.phase_increment + bus.fm_input;
        sum    = {1'b0, phase_q[voice_cnt_q]} + {1'b0, freq};
        lookup = phase_q[voice_cnt_q] + bus.phase_offset;
    end

    always_comb begin
        state_d      = state_q;
        voice_cnt_d  = voice_cnt_q;
        sync_d       = sync_q;
        phase_d      = phase_q;
        out_valid_d  = 1'b0;
        out_voice_d  = out_voice_q;
        addr_d       = addr_q;
        interp_d     = interp_q;
        wrapped_d    = wrapped_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                wrapped_d = 1'b0;
                if (bus.sample_tick) begin
                    sync_d      = bus.sync_mask;
                    voice_cnt_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // A tick during a frame is dropped, even on the last voice's update cycle.
                overrun_d = bus.sample_tick;
                if (bus.En) begin
                    phase_d[voice_cnt_q] = sync_q[voice_cnt_q] ? '0 : sum[DW-1:0];
                    out_valid_d          = 1'b1;
                    out_voice_d          = voice_cnt_q;
                    {addr_d, interp_d}   = lookup;
                    wrapped_d            = ~sync_q[voice_cnt_q] & sum[DW];
                    sync_d[voice_cnt_q]  = 1'b0;
                    if (voice_cnt_q == VW'(NV - 1)) begin
                        frame_done_d = 1'b1;
                        voice_cnt_d  = '0;
                        state_d      = IDLE;
                    end else begin
                        voice_cnt_d = voice_cnt_q + VW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            voice_cnt_q  <= '0;
            sync_q       <= '0;
            for (int v = 0; v < NV; v++) phase_q[v] <= '0;
            out_valid_q  <= 1'b0;
            out_voice_q  <= '0;
            addr_q       <= '0;
            interp_q     <= '0;
            wrapped_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            voice_cnt_q  <= voice_cnt_d;
            sync_q       <= sync_d;
            phase_q      <= phase_d;
            out_valid_q  <= out_valid_d;
            out_voice_q  <= out_voice_d;
            addr_q       <= addr_d;
            interp_q     <= interp_d;
            wrapped_q    <= wrapped_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.req_voice      = voice_cnt_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_voice      = out_voice_q;
    assign bus.wavetable_addr = addr_q;
    assign bus.interp         = interp_q;
    assign bus.wrapped        = wrapped_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_phasor_bank.sv
// Directed bench for phasor_bank with NV=4, DW=32 and AW=12.
// The expected addresses are worked out by hand from the per-voice phase history.
module tb_phasor_bank;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] inc_tab [4];
    logic [31:0] fm_tab  [4];
    logic [31:0] off_val;

    phasor_bank_if #(.DW(32), .AW(12), .NV(4)) bus ();

    phasor_bank #(.DW(32), .AW(12), .NV(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Parameter register file: answers req_voice in the same cycle.
    always_comb begin
        bus.phase_increment = inc_tab[bus.req_voice];
        bus.fm_input        = fm_tab[bus.req_voice];
        bus.phase_offset    = off_val;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},  64'(bus.out_valid), 64'd0);
        check({tag, "_voice"},  64'(bus.out_voice), 64'd0);
        check({tag, "_addr"},   64'(bus.wavetable_addr), 64'd0);
        check({tag, "_interp"}, 64'(bus.interp), 64'd0);
        check({tag, "_wrap"},   64'(bus.wrapped), 64'd0);
        check({tag, "_done"},   64'(bus.frame_done), 64'd0);
        check({tag, "_ovr"},    64'(bus.overrun), 64'd0);
        check({tag, "_req"},    64'(bus.req_voice), 64'd0);
    endtask

    task automatic start_frame();
        bus.sample_tick = 1'b1;
        tick();
        bus.sample_tick = 1'b0;
        check("start_valid", 64'(bus.out_valid), 64'd0);
    endtask

    // Service one voice and check the output it registers.
    task automatic svc(input int v, input logic [11:0] a, input logic [19:0] ip,
                       input logic w, input logic done, input logic ovr);
        check("req_voice", 64'(bus.req_voice), 64'(v));
        tick();
        check("out_valid",  64'(bus.out_valid), 64'd1);
        check("out_voice",  64'(bus.out_voice), 64'(v));
        check("addr",       64'(bus.wavetable_addr), 64'(a));
        check("interp",     64'(bus.interp), 64'(ip));
        check("wrapped",    64'(bus.wrapped), 64'(w));
        check("frame_done", 64'(bus.frame_done), 64'(done));
        check("overrun",    64'(bus.overrun), 64'(ovr));
    endtask

    initial begin
        bus.En = 1'b1;
        bus.sample_tick = 1'b0;
        bus.sync_mask = '0;
        off_val = '0;
        for (int i = 0; i < 4; i++) begin
            inc_tab[i] = 32'h0010_0000;
            fm_tab[i]  = '0;
        end

        // Power-on reset
        repeat (3) tick();
        check_zero("reset");
        Reset_n = 1'b1;
        tick();

        // Equal increments over three frames: the address tracks the frame index
        for (int k = 0; k < 3; k++) begin
            start_frame();
            for (int v = 0; v < 4; v++) svc(v, 12'(k), 20'h0, 1'b0, v == 3, 1'b0);
        end

        // Asynchronous reset in the middle of a frame, between clock edges
        start_frame();
        svc(0, 12'h003, 20'h0, 1'b0, 1'b0, 1'b0);
        Reset_n = 1'b0;
        #2;
        check_zero("midreset");
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        // Voice 1 has a large increment and wraps in frames 1 and 2
        inc_tab[1] = 32'hC000_0000;
        start_frame();
        for (int v = 0; v < 4; v++) svc(v, 12'h000, 20'h0, 1'b0, v == 3, 1'b0);
        start_frame();
        svc(0, 12'h001, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(1, 12'hC00, 20'h0, 1'b1, 1'b0, 1'b0);
        svc(2, 12'h001, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(3, 12'h001, 20'h0, 1'b0, 1'b1, 1'b0);
        start_frame();
        svc(0, 12'h002, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(1, 12'h800, 20'h0, 1'b1, 1'b0, 1'b0);
        svc(2, 12'h002, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(3, 12'h002, 20'h0, 1'b0, 1'b1, 1'b0);

        // Hard sync on voice 2: the carry is masked and the old phase is still shown
        bus.sync_mask = 4'b0100;
        inc_tab[2] = 32'hFFF0_0000;
        start_frame();
        bus.sync_mask = '0;
        svc(0, 12'h003, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(1, 12'h400, 20'h0, 1'b1, 1'b0, 1'b0);
        svc(2, 12'h003, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(3, 12'h003, 20'h0, 1'b0, 1'b1, 1'b0);
        inc_tab[2] = 32'h0010_0000;
        off_val = 32'h1230_0AB0;
        start_frame();
        svc(0, 12'h127, 20'h00AB0, 1'b0, 1'b0, 1'b0);
        svc(1, 12'h123, 20'h00AB0, 1'b0, 1'b0, 1'b0);
        svc(2, 12'h123, 20'h00AB0, 1'b0, 1'b0, 1'b0);
        svc(3, 12'h127, 20'h00AB0, 1'b0, 1'b1, 1'b0);
        off_val = '0;

        // En held low for 3 cycles with voice 2 pending; negative FM cancels voice 3's increment
        fm_tab[3] = 32'hFFF0_0000;
        start_frame();
        svc(0, 12'h005, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(1, 12'hC00, 20'h0, 1'b1, 1'b0, 1'b0);
        bus.En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req",   64'(bus.req_voice), 64'd2);
            check("stall_valid", 64'(bus.out_valid), 64'd0);
            check("stall_done",  64'(bus.frame_done), 64'd0);
            check("stall_addr",  64'(bus.wavetable_addr), 64'hC00);
            check("stall_wrap",  64'(bus.wrapped), 64'd1);
        end
        bus.En = 1'b1;
        svc(2, 12'h001, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(3, 12'h005, 20'h0, 1'b0, 1'b1, 1'b0);
        fm_tab[3] = '0;

        // A sample_tick at voice 1 is dropped and flagged as overrun
        start_frame();
        svc(0, 12'h006, 20'h0, 1'b0, 1'b0, 1'b0);
        bus.sample_tick = 1'b1;
        svc(1, 12'h800, 20'h0, 1'b1, 1'b0, 1'b1);
        bus.sample_tick = 1'b0;
        svc(2, 12'h002, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(3, 12'h005, 20'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check("no_restart_valid", 64'(bus.out_valid), 64'd0);

        // A tick on the last voice's update also counts as overrun and does not start a frame
        start_frame();
        svc(0, 12'h007, 20'h0, 1'b0, 1'b0, 1'b0);
        svc(1, 12'h400, 20'h0, 1'b1, 1'b0, 1'b0);
        svc(2, 12'h003, 20'h0, 1'b0, 1'b0, 1'b0);
        bus.sample_tick = 1'b1;
        svc(3, 12'h006, 20'h0, 1'b0, 1'b1, 1'b1);
        bus.sample_tick = 1'b0;
        tick();
        check("last_ovr_valid", 64'(bus.out_valid), 64'd0);
        check("last_ovr_pulse", 64'(bus.overrun), 64'd0);
        check("idle_req",       64'(bus.req_voice), 64'd0);
        check("idle_wrap",      64'(bus.wrapped), 64'd0);
        tick();
        check("last_ovr_norun", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
